// File: rtl/mod_exp_param.sv
// Modular exponentiation result = a^b mod m.
// The exponent is scanned LSB first (right-to-left binary method). A
// restoring divider reduces the base, and one interleaved shift-add modular
// multiplier is shared by the multiply and square steps.
module mod_exp_param #(
   parameter int WIDTH     = 256,
   parameter int EXP_WIDTH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [EXP_WIDTH-1:0] b,
   input  logic [WIDTH-1:0]     m,
   output logic [WIDTH-1:0]     result,
   output logic                 done,
   output logic                 busy,
   output logic                 error
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD, REDUCE, EXP_TEST, MUL, SQR, SHIFT, FINISH
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]     a_r;          // base operand, shifted out MSB first
   logic [EXP_WIDTH-1:0] e_r;          // remaining exponent
   logic [WIDTH-1:0]     m_r;          // captured modulus
   logic [WIDTH:0]       r_r;          // reduction remainder
   logic [WIDTH-1:0]     base_r;
   logic [WIDTH-1:0]     acc_r;
   logic [WIDTH-1:0]     mx_r;         // multiplier scanned operand
   logic [WIDTH-1:0]     my_r;         // multiplier added operand
   logic [WIDTH+1:0]     mp_r;         // multiplier partial product
   logic [CNT_W-1:0]     cnt_r;
   logic                 mul_first_r;  // next MUL/SQR cycle is the setup cycle
   logic [WIDTH:0]       red_next;
   logic [WIDTH+1:0]     mp_next;
   logic                 mul_last;

   // One restoring shift-subtract step: r = 2r + bit, minus m when r >= m.
   function automatic logic [WIDTH:0] reduce_step(input logic [WIDTH:0]   r,
                                                  input logic             bit_in,
                                                  input logic [WIDTH-1:0] mod);
      logic [WIDTH:0] t;
      t = (r << 1) + {{WIDTH{1'b0}}, bit_in};
      if (t >= {1'b0, mod})
         t = t - {1'b0, mod};
      return t;
   endfunction

   // One interleaved multiply step: p = 2p + x_i*y, then up to two
   // subtractions of m. p < m on entry so 2p + y < 3m fits in WIDTH+2 bits.
   function automatic logic [WIDTH+1:0] mul_step(input logic [WIDTH+1:0] p,
                                                 input logic             xi,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] mod);
      logic [WIDTH+1:0] t;
      t = (p << 1) + (xi ? {2'b00, y} : '0);
      if (t >= {2'b00, mod})
         t = t - {2'b00, mod};
      if (t >= {2'b00, mod})
         t = t - {2'b00, mod};
      return t;
   endfunction

   // Next values of the two arithmetic step units.
   always_comb begin
      red_next = reduce_step(r_r, a_r[WIDTH-1], m_r);
      mp_next  = mul_step(mp_r, mx_r[WIDTH-1], my_r, m_r);
      mul_last = !mul_first_r && (cnt_r == '0);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (start) state_nxt = LOAD;
         LOAD:     state_nxt = (m_r == '0) ? FINISH : REDUCE;
         REDUCE:   if (cnt_r == '0) state_nxt = EXP_TEST;
         EXP_TEST: begin
            if (e_r == '0)
               state_nxt = FINISH;
            else if (e_r[0])
               state_nxt = MUL;
            else
               state_nxt = SQR;
         end
         MUL:      if (mul_last) state_nxt = SQR;
         SQR:      if (mul_last) state_nxt = SHIFT;
         SHIFT:    state_nxt = EXP_TEST;
         FINISH:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs, advanced according to the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r         <= '0;
         e_r         <= '0;
         m_r         <= '0;
         r_r         <= '0;
         base_r      <= '0;
         acc_r       <= '0;
         mx_r        <= '0;
         my_r        <= '0;
         mp_r        <= '0;
         cnt_r       <= '0;
         mul_first_r <= 1'b0;
         result      <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  e_r   <= b;
                  m_r   <= m;
                  done  <= 1'b0;
                  busy  <= 1'b1;
                  error <= 1'b0;
               end else begin
                  done  <= 1'b1;
               end
            end
            LOAD: begin
               if (m_r == '0) begin
                  error  <= 1'b1;
                  result <= '0;
               end else begin
                  error  <= 1'b0;
                  r_r    <= '0;
                  cnt_r  <= CNT_W'(WIDTH - 1);
               end
            end
            REDUCE: begin
               r_r   <= red_next;
               a_r   <= a_r << 1;
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == '0) begin
                  base_r <= red_next[WIDTH-1:0];
                  acc_r  <= (m_r == WIDTH'(1)) ? '0 : WIDTH'(1);
               end
            end
            EXP_TEST: begin
               mul_first_r <= 1'b1;
            end
            MUL, SQR: begin
               if (mul_first_r) begin
                  mx_r        <= (state == MUL) ? acc_r : base_r;
                  my_r        <= base_r;
                  mp_r        <= '0;
                  cnt_r       <= CNT_W'(WIDTH - 1);
                  mul_first_r <= 1'b0;
               end else begin
                  mp_r  <= mp_next;
                  mx_r  <= mx_r << 1;
                  cnt_r <= cnt_r - CNT_W'(1);
                  if (cnt_r == '0) begin
                     if (state == MUL) begin
                        acc_r       <= mp_next[WIDTH-1:0];
                        mul_first_r <= 1'b1;
                     end else begin
                        base_r      <= mp_next[WIDTH-1:0];
                     end
                  end
               end
            end
            SHIFT: begin
               e_r <= e_r >> 1;
            end
            FINISH: begin
               if (!error)
                  result <= acc_r;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_param.sv
// Bench for mod_exp_param at WIDTH=16, EXP_WIDTH=16: fixed vectors, random
// jobs against an arithmetic model, held start and mid-job reset.
module tb_mod_exp_param;

   localparam int W  = 16;
   localparam int EW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [EW-1:0] b;
   logic [W-1:0]  m;
   logic [W-1:0]  result;
   logic          done;
   logic          busy;
   logic          error;

   int n_vec = 0;
   int n_bad = 0;

   mod_exp_param #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .m      (m),
      .result (result),
      .done   (done),
      .busy   (busy),
      .error  (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  a;
      logic [EW-1:0] b;
      logic [W-1:0]  m;
      logic [W-1:0]  res;
      logic          err;
   } vec_t;

   vec_t tbl[9];

   function automatic longint ref_modexp(input longint ra, input longint rb, input longint rm);
      longint r, base, e;
      if (rm == 0) return 0;
      r    = 1 % rm;
      base = ra % rm;
      e    = rb;
      while (e != 0) begin
         if ((e & 1) != 0) r = (r * base) % rm;
         base = (base * base) % rm;
         e    = e >> 1;
      end
      return r;
   endfunction

   // Cycles from the accepting edge (counted as 1) to the edge that raises done.
   function automatic int ref_cycles(input longint rb, input longint rm);
      int n;
      longint e;
      if (rm == 0) return 3;
      n = W + 4;
      e = rb;
      while (e != 0) begin
         n += W + 3;
         if ((e & 1) != 0) n += W + 1;
         e = e >> 1;
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input logic [W-1:0] ja, input logic [EW-1:0] jb, input logic [W-1:0] jm,
                          output logic [W-1:0] r, output logic e, output int cyc, output bit busy_ok);
      @(negedge clk);
      a = ja; b = jb; m = jm; start = 1'b1;
      cyc = 0;
      busy_ok = 1'b1;
      while (cyc < 5000) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0;
            a = W'($urandom);
            b = EW'($urandom);
            m = W'($urandom);
         end
         if (cyc >= 2 && done) break;
         if (!busy) busy_ok = 1'b0;
      end
      r = result;
      e = error;
   endtask

   task automatic job_and_check(input string tag, input logic [W-1:0] ja, input logic [EW-1:0] jb,
                                input logic [W-1:0] jm, input logic [W-1:0] xres, input logic xerr);
      logic [W-1:0] r;
      logic         e;
      int           cyc;
      bit           bok;
      run_job(ja, jb, jm, r, e, cyc, bok);
      check({tag, ".result"}, r, xres);
      check({tag, ".error"}, e, xerr);
      check({tag, ".cycles"}, cyc, ref_cycles(jb, jm));
      check({tag, ".busy"}, bok, 1);
   endtask

   initial begin
      logic [W-1:0]  ra, rm;
      logic [EW-1:0] rb;
      int            c_len, rises, glitches, cyc;
      logic          prev_done;

      tbl[0] = '{a: 16'd4,     b: 16'd13,    m: 16'd497,   res: 16'd445,  err: 1'b0};
      tbl[1] = '{a: 16'd600,   b: 16'd1,     m: 16'd497,   res: 16'd103,  err: 1'b0};
      tbl[2] = '{a: 16'd3,     b: 16'd0,     m: 16'd7,     res: 16'd1,    err: 1'b0};
      tbl[3] = '{a: 16'd3,     b: 16'd0,     m: 16'd1,     res: 16'd0,    err: 1'b0};
      tbl[4] = '{a: 16'd5,     b: 16'd7,     m: 16'd0,     res: 16'd0,    err: 1'b1};
      tbl[5] = '{a: 16'd2,     b: 16'd10,    m: 16'd1000,  res: 16'd24,   err: 1'b0};
      tbl[6] = '{a: 16'd65535, b: 16'd3,     m: 16'd65521, res: 16'd2744, err: 1'b0};
      tbl[7] = '{a: 16'd65535, b: 16'd65535, m: 16'd65535, res: 16'd0,    err: 1'b0};
      tbl[8] = '{a: 16'd0,     b: 16'd0,     m: 16'd5,     res: 16'd1,    err: 1'b0};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.done", done, 0);
      check("reset.busy", busy, 0);
      check("reset.error", error, 0);
      check("reset.result", result, 0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_reset.done", done, 1);

      for (int i = 0; i < 9; i++)
         job_and_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].res, tbl[i].err);

      for (int i = 0; i < 40; i++) begin
         int sel;
         int nb;
         ra  = W'($urandom);
         nb  = $urandom_range(0, 16);
         rb  = EW'($urandom & ((32'd1 << nb) - 32'd1));
         sel = $urandom_range(0, 9);
         if (sel == 0)      rm = '0;
         else if (sel <= 3) rm = W'($urandom_range(1, 20));
         else               rm = W'($urandom_range(1, 65535));
         job_and_check($sformatf("rnd%0d", i), ra, rb, rm,
                       W'(ref_modexp(ra, rb, rm)), (rm == 0));
      end

      // start held high: one job per acceptance, done and busy complementary.
      c_len = ref_cycles(5, 13);
      rises = 0; glitches = 0; prev_done = 1'b1;
      @(negedge clk);
      a = 16'd3; b = 16'd5; m = 16'd13; start = 1'b1;
      for (int k = 1; k <= 2 * c_len + 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy === done) glitches++;
         if (done && !prev_done) begin
            rises++;
            check("held.result", result, W'(ref_modexp(3, 5, 13)));
         end
         prev_done = done;
      end
      check("held.completions", rises, 2);
      check("held.glitches", glitches, 0);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      check("held.drain_done", done, 1);
      check("held.drain_result", result, W'(ref_modexp(3, 5, 13)));

      // Reset in the middle of a square step.
      @(negedge clk);
      a = 16'd3; b = 16'd2; m = 16'd11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (24) @(posedge clk);
      @(negedge clk);
      check("mid.busy_before", busy, 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_reset.done", done, 0);
      check("mid_reset.busy", busy, 0);
      check("mid_reset.result", result, 0);
      check("mid_reset.error", error, 0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("after_abort.done", done, 1);
      check("after_abort.result", result, 0);

      job_and_check("post_abort", 16'd7, 16'd9, 16'd100, W'(ref_modexp(7, 9, 100)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
